// File: rtl/riscv_control_unit_if.sv
// Control/status bundle between the RV64 multi-cycle sequencer and its datapath.
// The master modport is the sequencer side; the slave modport is the datapath side.
interface riscv_control_unit_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 start;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 flag_equal;
    logic                 flag_not_equal;
    logic                 flag_less;
    logic                 flag_greater;
    logic                 flag_u_equal;
    logic                 flag_u_less;
    logic                 flag_u_greater;
    logic                 mem_ready;
    logic                 rf_write_en;
    logic                 dm_write_en;
    logic                 dm_read_en;
    logic                 alu_src;
    logic                 mem_to_reg;
    logic                 pc_src;
    logic                 finished;
    logic                 halted;
    logic [1:0]           fault;
    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        input  start, opcode, funct3,
        input  flag_equal, flag_not_equal, flag_less, flag_greater,
        input  flag_u_equal, flag_u_less, flag_u_greater, mem_ready,
        output rf_write_en, dm_write_en, dm_read_en, alu_src, mem_to_reg,
        output pc_src, finished, halted, fault, state, retired
    );

    modport slave (
        output start, opcode, funct3,
        output flag_equal, flag_not_equal, flag_less, flag_greater,
        output flag_u_equal, flag_u_less, flag_u_greater, mem_ready,
        input  rf_write_en, dm_write_en, dm_read_en, alu_src, mem_to_reg,
        input  pc_src, finished, halted, fault, state, retired
    );
endinterface

// File: rtl/riscv_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the RV64 datapath,
// with branch resolution, SYSTEM/illegal/memory-timeout halting and a retire counter.
module riscv_control_unit #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    riscv_control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL
    } class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_MEM     = 2'b10;
    localparam logic [1:0] FAULT_SYSTEM  = 2'b11;

    localparam int unsigned       WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_e               state_q, state_d;
    class_e               cls_q, cls_d;
    logic [2:0]           f3_q, f3_d;
    logic                 alu_src_q, alu_src_d;
    logic                 mem_to_reg_q, mem_to_reg_d;
    logic [1:0]           fault_q, fault_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;
    logic                 rf_we_q, rf_we_d;
    logic                 dm_we_q, dm_we_d;
    logic                 dm_re_q, dm_re_d;
    logic                 fin_q, fin_d;
    logic                 pc_jal_q, pc_jal_d;
    logic                 halted_q, halted_d;
    logic                 taken, branch_retire, store_done, finished;

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        f3_d         = f3_q;
        alu_src_d    = alu_src_q;
        mem_to_reg_d = mem_to_reg_q;
        fault_d      = fault_q;
        wait_d       = wait_q;

        taken = 1'b0;
        case (f3_q)
            3'b000:  taken = bus.flag_equal;
            3'b001:  taken = bus.flag_not_equal;
            3'b100:  taken = bus.flag_less;
            3'b101:  taken = bus.flag_greater | bus.flag_equal;
            3'b110:  taken = bus.flag_u_less;
            3'b111:  taken = bus.flag_u_greater | bus.flag_u_equal;
            default: taken = 1'b0;
        endcase

        // Branch and store retire in-state (flags / mem_ready arrive that cycle); the rest retire in WRITEBACK.
        branch_retire = (state_q == S_EXECUTE) && (cls_q == CLS_BRANCH);
        store_done    = (state_q == S_MEMORY) && (cls_q == CLS_STORE) && bus.mem_ready;
        finished      = fin_q | branch_retire | store_done;
        retired_d     = finished ? retired_q + CNT_WIDTH'(1) : retired_q;

        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                state_d      = S_EXECUTE;
                f3_d         = bus.funct3;
                alu_src_d    = 1'b0;
                mem_to_reg_d = 1'b0;
                case (bus.opcode)
                    OP_R:     cls_d = CLS_R;
                    OP_I:     begin cls_d = CLS_I;     alu_src_d = 1'b1; end
                    OP_LOAD:  begin cls_d = CLS_LOAD;  alu_src_d = 1'b1; mem_to_reg_d = 1'b1; end
                    OP_STORE: begin cls_d = CLS_STORE; alu_src_d = 1'b1; end
                    OP_BRANCH: begin
                        cls_d = CLS_BRANCH;
                        if (bus.funct3[2:1] == 2'b01) begin
                            state_d = S_HALT;
                            fault_d = FAULT_ILLEGAL;
                        end
                    end
                    OP_JAL:    cls_d = CLS_JAL;
                    OP_SYSTEM: begin state_d = S_HALT; fault_d = FAULT_SYSTEM; end
                    default:   begin state_d = S_HALT; fault_d = FAULT_ILLEGAL; end
                endcase
            end
            S_EXECUTE: begin
                wait_d = '0;
                case (cls_q)
                    CLS_BRANCH:          state_d = S_FETCH;
                    CLS_LOAD, CLS_STORE: state_d = S_MEMORY;
                    default:             state_d = S_WRITEBACK;
                endcase
            end
            S_MEMORY: begin
                if (bus.mem_ready) begin
                    state_d = (cls_q == CLS_LOAD) ? S_WRITEBACK : S_FETCH;
                end else if ((MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
                    state_d = S_HALT;
                    fault_d = FAULT_MEM;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_IDLE;
        endcase

        if (state_d == S_FETCH || state_d == S_IDLE) begin
            alu_src_d    = 1'b0;
            mem_to_reg_d = 1'b0;
        end

        // Moore strobes registered from the next state so they line up with the state they belong to.
        rf_we_d  = (state_d == S_WRITEBACK);
        fin_d    = (state_d == S_WRITEBACK);
        pc_jal_d = (state_d == S_WRITEBACK) && (cls_d == CLS_JAL);
        dm_we_d  = (state_d == S_MEMORY) && (cls_d == CLS_STORE);
        dm_re_d  = (state_d == S_MEMORY) && (cls_d == CLS_LOAD);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cls_q        <= CLS_R;
            f3_q         <= '0;
            alu_src_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            fault_q      <= '0;
            wait_q       <= '0;
            retired_q    <= '0;
            rf_we_q      <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_re_q      <= 1'b0;
            fin_q        <= 1'b0;
            pc_jal_q     <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            f3_q         <= f3_d;
            alu_src_q    <= alu_src_d;
            mem_to_reg_q <= mem_to_reg_d;
            fault_q      <= fault_d;
            wait_q       <= wait_d;
            retired_q    <= retired_d;
            rf_we_q      <= rf_we_d;
            dm_we_q      <= dm_we_d;
            dm_re_q      <= dm_re_d;
            fin_q        <= fin_d;
            pc_jal_q     <= pc_jal_d;
            halted_q     <= halted_d;
        end
    end

    assign bus.rf_write_en = rf_we_q;
    assign bus.dm_write_en = dm_we_q;
    assign bus.dm_read_en  = dm_re_q;
    assign bus.alu_src     = alu_src_q;
    assign bus.mem_to_reg  = mem_to_reg_q;
    assign bus.pc_src      = branch_retire ? taken : pc_jal_q;
    assign bus.finished    = finished;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.state       = state_q;
    assign bus.retired     = retired_q;
endmodule

// File: tb/tb_riscv_control_unit.sv
// Scoreboard bench for riscv_control_unit: the driver queues the expected retire/halt
// record per instruction, a monitor pops it when finished pulses or halted rises.
module tb_riscv_control_unit;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct {
        bit          halt;
        int unsigned lat;
        logic [2:0]  st;
        logic        pc;
        int unsigned rd;
        int unsigned wr;
        int unsigned rf;
        logic        m2r;
        bit          chk_alu;
        logic        alu;
        logic [1:0]  flt;
        logic [31:0] ret;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int unsigned mem_wait = 0;
    exp_t sb[$];

    riscv_control_unit_if #(.CNT_WIDTH(32)) bus ();

    riscv_control_unit #(.CNT_WIDTH(32), .MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic exp_t ex_ret(input int unsigned lat, input logic [2:0] st, input logic pc,
                                    input int unsigned rd, input int unsigned wr, input int unsigned rf,
                                    input logic m2r, input bit ca, input logic alu, input logic [31:0] ret);
        exp_t e;
        e.halt = 1'b0; e.lat = lat; e.st = st; e.pc = pc; e.rd = rd; e.wr = wr; e.rf = rf;
        e.m2r = m2r; e.chk_alu = ca; e.alu = alu; e.flt = 2'b00; e.ret = ret;
        return e;
    endfunction

    function automatic exp_t ex_halt(input int unsigned lat, input logic [1:0] flt,
                                     input int unsigned wr, input logic [31:0] ret);
        exp_t e;
        e.halt = 1'b1; e.lat = lat; e.st = 3'd6; e.pc = 1'b0; e.rd = 0; e.wr = wr; e.rf = 0;
        e.m2r = 1'b0; e.chk_alu = 1'b0; e.alu = 1'b0; e.flt = flt; e.ret = ret;
        return e;
    endfunction

    // Data-memory responder: raises mem_ready after mem_wait MEMORY cycles.
    initial begin
        int unsigned mcnt;
        mcnt = 0;
        bus.mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.state == 3'd4) begin
                bus.mem_ready = (mcnt >= mem_wait);
                mcnt++;
            end else begin
                bus.mem_ready = 1'b0;
                mcnt = 0;
            end
        end
    end

    // Monitor: per-instruction cycle and strobe tallies, compared on each retire/halt event.
    initial begin
        int unsigned cyc, rd, wr, rf;
        bit halted_prev;
        exp_t e;
        cyc = 0; rd = 0; wr = 0; rf = 0; halted_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                cyc = 0; rd = 0; wr = 0; rf = 0; halted_prev = 1'b0;
            end else begin
                if (bus.state == 3'd1) begin
                    cyc = 1; rd = 0; wr = 0; rf = 0;
                end else begin
                    cyc++;
                end
                if (bus.dm_read_en)  rd++;
                if (bus.dm_write_en) wr++;
                if (bus.rf_write_en) rf++;
                if (bus.finished || (bus.halted && !halted_prev)) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_event: finished=%0b halted=%0b state=%0d with nothing expected",
                                 bus.finished, bus.halted, bus.state);
                    end else begin
                        e = sb.pop_front();
                        chk("event_kind_halted", 32'(bus.halted), 32'(e.halt));
                        chk("latency", cyc, e.lat);
                        chk("event_state", 32'(bus.state), 32'(e.st));
                        chk("dm_read_cycles", rd, e.rd);
                        chk("dm_write_cycles", wr, e.wr);
                        chk("rf_write_cycles", rf, e.rf);
                        chk("fault", 32'(bus.fault), 32'(e.flt));
                        chk("retired", bus.retired, e.ret);
                        if (!e.halt) begin
                            chk("pc_src", 32'(bus.pc_src), 32'(e.pc));
                            chk("mem_to_reg", 32'(bus.mem_to_reg), 32'(e.m2r));
                            if (e.chk_alu) chk("alu_src", 32'(bus.alu_src), 32'(e.alu));
                        end else begin
                            chk("halt_finished", 32'(bus.finished), 32'd0);
                        end
                    end
                end
                halted_prev = bus.halted;
            end
        end
    end

    task automatic wait_state(input logic [2:0] s, input int unsigned lim, input string nm, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < lim; i++) begin
            if (bus.state == s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout, state %0d required %0d", nm, bus.state, s);
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] flags,
                             input int unsigned wt, input bit push, input exp_t e);
        bit ok;
        wait_state(3'd1, 100, "wait_fetch", ok);
        if (!ok) return;
        bus.opcode = op;
        bus.funct3 = f3;
        {bus.flag_equal, bus.flag_not_equal, bus.flag_less, bus.flag_greater,
         bus.flag_u_equal, bus.flag_u_less, bus.flag_u_greater} = flags;
        mem_wait = wt;
        if (push) sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_halt_then_reset();
        bit ok;
        wait_state(3'd6, 60, "wait_halt", ok);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t none;
        none = ex_halt(0, 2'b00, 0, 0);
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.opcode = '0;
        bus.funct3 = '0;
        {bus.flag_equal, bus.flag_not_equal, bus.flag_less, bus.flag_greater,
         bus.flag_u_equal, bus.flag_u_less, bus.flag_u_greater} = '0;

        #3;
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_outputs", 32'({bus.rf_write_en, bus.dm_write_en, bus.dm_read_en, bus.alu_src,
                                  bus.mem_to_reg, bus.pc_src, bus.finished, bus.halted, bus.fault}), 32'd0);
        chk("reset_retired", bus.retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_without_start", 32'(bus.state), 32'd0);

        // Retiring mix; flags = {eq, ne, lt, gt, ueq, ult, ugt}
        do_start();
        run_instr(OP_R,      3'b000, 7'b0000000, 0, 1'b1, ex_ret(4, 3'd5, 1'b0, 0, 0, 1, 1'b0, 1'b1, 1'b0, 0));
        run_instr(OP_LOAD,   3'b011, 7'b0000000, 3, 1'b1, ex_ret(8, 3'd5, 1'b0, 4, 0, 1, 1'b1, 1'b1, 1'b1, 1));
        run_instr(OP_STORE,  3'b011, 7'b0000000, 0, 1'b1, ex_ret(4, 3'd4, 1'b0, 0, 1, 0, 1'b0, 1'b1, 1'b1, 2));
        run_instr(OP_BRANCH, 3'b101, 7'b1000000, 0, 1'b1, ex_ret(3, 3'd3, 1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b0, 3));
        run_instr(OP_BRANCH, 3'b110, 7'b1111101, 0, 1'b1, ex_ret(3, 3'd3, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 4));
        run_instr(OP_JAL,    3'b000, 7'b0000000, 0, 1'b1, ex_ret(4, 3'd5, 1'b1, 0, 0, 1, 1'b0, 1'b0, 1'b0, 5));
        run_instr(OP_I,      3'b000, 7'b0000000, 0, 1'b1, ex_ret(4, 3'd5, 1'b0, 0, 0, 1, 1'b0, 1'b1, 1'b1, 6));
        run_instr(OP_BRANCH, 3'b000, 7'b1000000, 0, 1'b1, ex_ret(3, 3'd3, 1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b0, 7));
        run_instr(OP_BRANCH, 3'b100, 7'b1101111, 0, 1'b1, ex_ret(3, 3'd3, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 8));
        run_instr(OP_BRANCH, 3'b111, 7'b0000100, 0, 1'b1, ex_ret(3, 3'd3, 1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b0, 9));
        run_instr(7'b0000000, 3'b000, 7'b0000000, 0, 1'b1, ex_halt(3, 2'b01, 0, 10));
        wait_halt_then_reset();

        // Branch with reserved funct3
        do_start();
        run_instr(OP_BRANCH, 3'b011, 7'b1111111, 0, 1'b1, ex_halt(3, 2'b01, 0, 0));
        wait_halt_then_reset();

        // SYSTEM; start must be ignored while halted
        do_start();
        run_instr(OP_SYSTEM, 3'b000, 7'b0000000, 0, 1'b1, ex_halt(3, 2'b11, 0, 0));
        begin
            bit ok;
            wait_state(3'd6, 30, "wait_system_halt", ok);
        end
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        chk("halt_sticky_state", 32'(bus.state), 32'd6);
        chk("halt_sticky_fault", 32'(bus.fault), 32'd3);
        chk("halt_sticky_halted", 32'(bus.halted), 32'd1);
        wait_halt_then_reset();

        // STORE with mem_ready stuck low -> timeout
        do_start();
        run_instr(OP_STORE, 3'b011, 7'b0000000, 1000, 1'b1, ex_halt(19, 2'b10, 15, 0));
        wait_halt_then_reset();

        // Asynchronous reset in the middle of a STORE
        do_start();
        run_instr(OP_R,     3'b000, 7'b0000000, 0,    1'b1, ex_ret(4, 3'd5, 1'b0, 0, 0, 1, 1'b0, 1'b1, 1'b0, 0));
        run_instr(OP_STORE, 3'b011, 7'b0000000, 1000, 1'b0, none);
        begin
            bit ok;
            wait_state(3'd4, 30, "wait_memory", ok);
        end
        repeat (2) @(negedge clk);
        chk("pre_reset_dm_write_en", 32'(bus.dm_write_en), 32'd1);
        chk("pre_reset_retired", bus.retired, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({bus.rf_write_en, bus.dm_write_en, bus.dm_read_en, bus.alu_src,
                                        bus.mem_to_reg, bus.pc_src, bus.finished, bus.halted, bus.fault}), 32'd0);
        chk("async_reset_state", 32'(bus.state), 32'd0);
        chk("async_reset_retired", bus.retired, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_needs_start", 32'(bus.state), 32'd0);
        do_start();
        run_instr(OP_R, 3'b000, 7'b0000000, 0, 1'b1, ex_ret(4, 3'd5, 1'b0, 0, 0, 1, 1'b0, 1'b1, 1'b0, 0));
        run_instr(7'b1111111, 3'b000, 7'b0000000, 0, 1'b1, ex_halt(3, 2'b01, 0, 1));
        wait_halt_then_reset();

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
